// File: rtl/ir_pkg.sv
// Shared IR/movement definitions: FSM states, default carrier-window constants, direction codes.
// Constants only; no logic, no latency, no flow control.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_EVAL    = 2'd2,
    ST_DONE    = 2'd3
  } ir_state_e;

  localparam int IR_GATE_CYCLES   = 50000;
  localparam int IR_MIN_EDGES     = 8;
  localparam int IR_MAX_EDGES     = 12;
  localparam int IR_MATCH_WINDOWS = 3;
  localparam int IR_MAX_WINDOWS   = 100;
  localparam int IR_CNT_W         = 8;

  // Direction codes as decoded by the movement FSM.
  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b0001;
  localparam logic [3:0] DIR_REV   = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

endpackage

// File: rtl/ir_edge_sync.sv
// IR pin to single-cycle rising-edge pulse: 2-FF sync (+ IR_DEBOUNCE_EN glitch filter), registered edge detect.
// Latency 3 clk from pin transition to pulse (plus DEBOUNCE_CYCLES when filtered); no backpressure.
module ir_edge_sync
`ifdef IR_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic ir_i,
  output logic edge_o
);

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ir_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef IR_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_q;
  logic            filt_q;

  // Level only follows the synchronizer after it disagrees for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else if (sync2_q == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q <= '0;
      filt_q   <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      pulse_q    <= lvl & ~lvl_prev_q;
    end
  end

  assign edge_o = pulse_q;

endmodule

// File: rtl/ir_beacon_detect.sv
// Beacon carrier detector: counts IR edges per gate window, reports found/timeout to the movement FSM.
// Done at best MATCH_WINDOWS*(GATE_CYCLES+1)+1 clk after Enable; no backpressure. Optional IR_DEBOUNCE_EN.
module ir_beacon_detect
  import ir_pkg::*;
#(
  parameter int GATE_CYCLES   = IR_GATE_CYCLES,
  parameter int MIN_EDGES     = IR_MIN_EDGES,
  parameter int MAX_EDGES     = IR_MAX_EDGES,
  parameter int MATCH_WINDOWS = IR_MATCH_WINDOWS,
  parameter int MAX_WINDOWS   = IR_MAX_WINDOWS,
  parameter int CNT_W         = IR_CNT_W
`ifdef IR_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IR,
  input  logic             EnableIRModule,
  input  logic             ResetIRModule,
  output logic             IRModuleDone,
  output logic             BeaconFound,
  output logic [CNT_W-1:0] EdgeCount
);

  localparam int TMR_W   = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int WIN_W   = $clog2(MAX_WINDOWS + 1);
  localparam int MATCH_W = $clog2(MATCH_WINDOWS + 1);

  logic edge_pulse;

  ir_edge_sync
`ifdef IR_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
  u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ir_i   (IR),
    .edge_o (edge_pulse)
  );

  ir_state_e          state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   ec_q, ec_d;
  logic               is_match;

  assign is_match = (edge_cnt_q >= CNT_W'(MIN_EDGES)) && (edge_cnt_q <= CNT_W'(MAX_EDGES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      match_q    <= '0;
      win_q      <= '0;
      found_q    <= 1'b0;
      ec_q       <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      match_q    <= match_d;
      win_q      <= win_d;
      found_q    <= found_d;
      ec_q       <= ec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    match_d    = match_q;
    win_d      = win_q;
    found_d    = found_q;
    ec_d       = ec_q;

    if (ResetIRModule) begin
      state_d    = ST_IDLE;
      timer_d    = '0;
      edge_cnt_d = '0;
      match_d    = '0;
      win_d      = '0;
      found_d    = 1'b0;
      ec_d       = '0;
    end else if (!EnableIRModule) begin
      // Last window's EdgeCount stays visible for debug after the controller lets go.
      state_d = ST_IDLE;
      found_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_MEASURE;
          timer_d    = '0;
          edge_cnt_d = '0;
          match_d    = '0;
          win_d      = '0;
          found_d    = 1'b0;
        end
        ST_MEASURE: begin
          if (edge_pulse && (edge_cnt_q != {CNT_W{1'b1}})) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
            state_d = ST_EVAL;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_EVAL: begin
          // Pulses arriving now are deliberately ignored; the next window starts from zero.
          ec_d    = edge_cnt_q;
          match_d = is_match ? (match_q + MATCH_W'(1)) : '0;
          win_d   = win_q + WIN_W'(1);
          if (is_match && (match_q == MATCH_W'(MATCH_WINDOWS - 1))) begin
            state_d = ST_DONE;
            found_d = 1'b1;
          end else if (win_q == WIN_W'(MAX_WINDOWS - 1)) begin
            state_d = ST_DONE;
            found_d = 1'b0;
          end else begin
            state_d    = ST_MEASURE;
            timer_d    = '0;
            edge_cnt_d = '0;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign IRModuleDone = (state_q == ST_DONE);
  assign BeaconFound  = found_q;
  assign EdgeCount    = ec_q;

endmodule

// File: tb/tb_ir_beacon_detect.sv
// Bench for ir_beacon_detect: square-wave table, hand-built corner sequences, random IR vs a window-level model.
module tb_ir_beacon_detect;

  localparam int G     = 100;
  localparam int MINE  = 4;
  localparam int MAXE  = 6;
  localparam int MATCH = 2;
  localparam int MAXW  = 5;
  localparam int CW    = 8;
  localparam int WIN   = G + 1;
  localparam int NCYC  = 1024;
  localparam int BOUND = 600;
`ifdef IR_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ir = 1'b0;
  logic          en = 1'b0;
  logic          rst_ir = 1'b0;
  logic          done;
  logic          found;
  logic [CW-1:0] ec;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit ir_arr [NCYC];
  int ec_obs [MAXW];
  int ec_exp [MAXW];

  typedef struct {
    int half;
    int ec;
    int fnd;
    int done_cyc;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  ir_beacon_detect #(
    .GATE_CYCLES(G), .MIN_EDGES(MINE), .MAX_EDGES(MAXE),
    .MATCH_WINDOWS(MATCH), .MAX_WINDOWS(MAXW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IR(ir), .EnableIRModule(en), .ResetIRModule(rst_ir),
    .IRModuleDone(done), .BeaconFound(found), .EdgeCount(ec)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ir_arr[j] is the IR level driven just after the j-th clock of a run.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    ir = (cyc < NCYC) ? ir_arr[cyc] : 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0; ir = 1'b0; rst_ir = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_arr();
    for (int j = 0; j < NCYC; j++) ir_arr[j] = 1'b0;
  endtask

  task automatic fill_square(input int half);
    for (int j = 0; j < NCYC; j++) ir_arr[j] = ((j % (2 * half)) >= half);
  endtask

  task automatic run_meas(input int bound, output int done_cyc, output int fnd);
    done_cyc = -1; fnd = 0;
    for (int w = 0; w < MAXW; w++) ec_obs[w] = -1;
    cyc = 0; ir = ir_arr[0]; en = 1'b1;
    while (done_cyc < 0 && cyc < bound) begin
      tick();
      for (int w = 0; w < MAXW; w++) if (cyc == WIN * (w + 1) + 1) ec_obs[w] = int'(ec);
      if (done) begin done_cyc = cyc; fnd = int'(found); end
    end
  endtask

  task automatic release_check(input string tag, input int exp_ec);
    en = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s disable done", tag), int'(done), 0);
    check($sformatf("%s disable found", tag), int'(found), 0);
    check($sformatf("%s disable ec kept", tag), int'(ec), exp_ec);
  endtask

  // Window-level reference: count rises landing inside each gate, then apply the streak/timeout rules.
  task automatic model(output int done_cyc, output int fnd);
    int streak;
    int lo, hi, n;
    streak = 0; done_cyc = -1; fnd = 0;
    for (int w = 0; w < MAXW; w++) ec_exp[w] = -1;
    for (int w = 0; w < MAXW && done_cyc < 0; w++) begin
      lo = 1 + WIN * w; hi = lo + G - 1; n = 0;
      for (int j = 1; j < NCYC; j++)
        if (ir_arr[j] && !ir_arr[j-1] && (j + LAT >= lo) && (j + LAT <= hi)) n++;
      if (n > (1 << CW) - 1) n = (1 << CW) - 1;
      ec_exp[w] = n;
      streak = (n >= MINE && n <= MAXE) ? streak + 1 : 0;
      if (streak == MATCH) begin done_cyc = WIN * (w + 1) + 1; fnd = 1; end
      else if (w == MAXW - 1) begin done_cyc = WIN * (w + 1) + 1; fnd = 0; end
    end
  endtask

  initial begin
    int d, f, md, mf, lvl, j, len, rlo, rhi;
    int streak_ec [4];

    tbl[0] = '{10,  5, 1, 203};
    tbl[1] = '{ 5, 10, 0, 506};
    tbl[2] = '{ 8,  6, 1, 203};
    tbl[3] = '{12,  4, 1, 203};
`ifdef IR_DEBOUNCE_EN
    tbl[4] = '{ 7,  8, 0, 506};
    tbl[5] = '{20,  2, 0, 506};
`else
    tbl[4] = '{ 7,  7, 0, 506};
    tbl[5] = '{20,  3, 0, 506};
`endif

    // Reset held with IR toggling
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; ir = ~ir; en = 1'b1; end
    check("reset done", int'(done), 0);
    check("reset found", int'(found), 0);
    check("reset ec", int'(ec), 0);
    en = 1'b0; ir = 1'b0;
    rst_n = 1'b1;
    idle(12);
    check("post-reset idle done", int'(done), 0);

    foreach (tbl[i]) begin
      fill_square(tbl[i].half);
      run_meas(BOUND, d, f);
      check($sformatf("tbl%0d done cycle", i), d, tbl[i].done_cyc);
      check($sformatf("tbl%0d found", i), f, tbl[i].fnd);
      check($sformatf("tbl%0d ec", i), int'(ec), tbl[i].ec);
      release_check($sformatf("tbl%0d", i), tbl[i].ec);
      idle(12);
    end

    // Asynchronous reset while holding a verdict
    fill_square(10);
    run_meas(BOUND, d, f);
    check("pre-arst done", int'(done), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst done", int'(done), 0);
    check("arst found", int'(found), 0);
    check("arst ec", int'(ec), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(12);

    // Streak broken: 5, 9, 5, 5 edges
    streak_ec = '{5, 9, 5, 5};
    clear_arr();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < streak_ec[w]; k++)
        for (int t = 0; t < 5; t++) ir_arr[1 + WIN * w + 10 + 10 * k - LAT + t] = 1'b1;
    run_meas(BOUND, d, f);
    check("streak done cycle", d, 405);
    check("streak found", f, 1);
    for (int w = 0; w < 4; w++) check($sformatf("streak ec w%0d", w), ec_obs[w], streak_ec[w]);
    release_check("streak", 5);
    idle(12);

    // ResetIRModule pulse mid-measurement with Enable held
    fill_square(10);
    d = -1; cyc = 0; ir = 1'b0; en = 1'b1;
    while (d < 0 && cyc < BOUND) begin
      tick();
      if (cyc == 150) begin check("abort ec before", int'(ec), 5); rst_ir = 1'b1; end
      if (cyc == 151) begin
        check("abort ec cleared", int'(ec), 0);
        check("abort done cleared", int'(done), 0);
        rst_ir = 1'b0;
      end
      if (done) d = cyc;
    end
    check("abort done cycle", d, 354);
    check("abort found", int'(found), 1);
    release_check("abort", 5);
    idle(12);

`ifdef IR_DEBOUNCE_EN
    // Glitches at 20-cycle spacing riding on a clean 40-cycle carrier
    for (int k = 0; k < NCYC; k++) begin
      ir_arr[k] = ((k % 40) >= 20);
      if ((k % 40) == 5 || (k % 40) == 6) ir_arr[k] = 1'b1;
      if ((k % 40) == 25 || (k % 40) == 26) ir_arr[k] = 1'b0;
    end
    run_meas(WIN + 1, d, f);
    check("debounce ec", ec_obs[0], 2);
    idle(12);
`endif

    // Random run-length IR against the window model
    for (int t = 0; t < 8; t++) begin
      clear_arr();
      rlo = $urandom_range(9, 5);
      rhi = rlo + $urandom_range(8, 0);
      lvl = 0; j = 1;
      while (j < NCYC) begin
        len = $urandom_range(rhi, rlo);
        for (int k = 0; k < len && j < NCYC; k++) begin ir_arr[j] = lvl[0]; j++; end
        lvl = 1 - lvl;
      end
      model(md, mf);
      run_meas(BOUND, d, f);
      check($sformatf("rnd%0d done cycle", t), d, md);
      check($sformatf("rnd%0d found", t), f, mf);
      for (int w = 0; w < MAXW; w++)
        if (ec_exp[w] >= 0) check($sformatf("rnd%0d ec w%0d", t, w), ec_obs[w], ec_exp[w]);
      idle(12);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
